terminal_writer: RTL

Upstream feeder of the character renderer's terminal-grid RAM write port. Accepts a stream of 8-bit character codes over a valid/ready handshake, maintains a text cursor, and issues single-cycle grid writes (`tg_write_en`/`tg_addr`/`tg_input`) for printable glyphs, backspace, newline, and full-screen clear. Runs in the pixel clock domain alongside the renderer.

---
 rtl/terminal_pkg.sv | 24 ++
 rtl/terminal_writer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/terminal_pkg.sv
// Shared constants and types for the terminal text writer.
package terminal_pkg;

  // Default grid geometry (character cells)
  localparam int TW_SCREEN_WIDTH  = 76;
  localparam int TW_SCREEN_HEIGHT = 44;

  // Glyph index stored into erased cells
  localparam logic [7:0] TW_BLANK_GLYPH = 8'h00;

  // Control codes; every other code is a printable glyph index
  localparam logic [7:0] CHAR_NEWLINE   = 8'h0A;
  localparam logic [7:0] CHAR_BACKSPACE = 8'h08;
  localparam logic [7:0] CHAR_CLEAR     = 8'h0C;

  // Writer sequencing states
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    CLEAR_ROW = 2'd2,
    CLEAR_ALL = 2'd3
  } tw_state_t;

endpackage

// File: rtl/terminal_writer.sv
// Character stream to terminal-grid writer: tracks a text cursor and issues
// single-cycle grid writes for glyphs, backspace, row clears and screen clears.
module terminal_writer
  import terminal_pkg::*;
#(
  parameter int         SCREEN_WIDTH  = TW_SCREEN_WIDTH,
  parameter int         SCREEN_HEIGHT = TW_SCREEN_HEIGHT,
  parameter logic [7:0] BLANK_GLYPH   = TW_BLANK_GLYPH,
  localparam int        CELLS         = SCREEN_WIDTH * SCREEN_HEIGHT,
  localparam int        AW            = $clog2(CELLS),
  localparam int        XW            = $clog2(SCREEN_WIDTH),
  localparam int        YW            = $clog2(SCREEN_HEIGHT)
) (
  input  logic          pixel_clk_in,
  input  logic          rst_in,
  input  logic [7:0]    char_in,
  input  logic          char_valid_in,
  output logic          char_ready_out,
  output logic          tg_write_en,
  output logic [AW-1:0] tg_addr,
  output logic [7:0]    tg_input,
  output logic [XW-1:0] cursor_x_out,
  output logic [YW-1:0] cursor_y_out
);

  // Clear counter must be able to hold the full cell count as its end marker
  localparam int            CW      = $clog2(CELLS + 1);
  localparam logic [XW-1:0] X_LAST  = XW'(SCREEN_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(SCREEN_HEIGHT - 1);
  localparam logic [AW-1:0] WIDTH_A = AW'(SCREEN_WIDTH);
  localparam logic [CW-1:0] ROW_END = CW'(SCREEN_WIDTH);
  localparam logic [CW-1:0] ALL_END = CW'(CELLS);

  tw_state_t     state;
  logic          ready;
  logic [XW-1:0] cursor_x;
  logic [YW-1:0] cursor_y;
  logic [CW-1:0] clear_cnt;
  logic          line_adv;

  logic [AW-1:0] row_base;
  logic [AW-1:0] cursor_addr;
  logic [YW-1:0] next_y;
  logic [XW-1:0] bs_x;
  logic [YW-1:0] bs_y;
  logic [AW-1:0] bs_addr;

  // Address and cursor-step arithmetic derived from the current cursor
  always_comb begin
    row_base    = AW'(cursor_y) * WIDTH_A;
    cursor_addr = row_base + AW'(cursor_x);
    next_y      = (cursor_y == Y_LAST) ? '0 : cursor_y + 1'b1;
    if (cursor_x != '0) begin
      bs_x = cursor_x - 1'b1;
      bs_y = cursor_y;
    end else begin
      bs_x = X_LAST;
      bs_y = cursor_y - 1'b1;
    end
    bs_addr = AW'(bs_y) * WIDTH_A + AW'(bs_x);
  end

  // Writer FSM: handshake, cursor movement and all grid write outputs
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      state       <= IDLE;
      ready       <= 1'b1;
      tg_write_en <= 1'b0;
      tg_addr     <= '0;
      tg_input    <= '0;
      cursor_x    <= '0;
      cursor_y    <= '0;
      clear_cnt   <= '0;
      line_adv    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tg_write_en <= 1'b0;
          if (char_valid_in && ready) begin
            ready    <= 1'b0;
            line_adv <= 1'b0;
            case (char_in)
              CHAR_CLEAR: begin
                // First blank write goes out immediately at address 0
                tg_write_en <= 1'b1;
                tg_addr     <= '0;
                tg_input    <= BLANK_GLYPH;
                clear_cnt   <= CW'(1);
                cursor_x    <= '0;
                cursor_y    <= '0;
                state       <= CLEAR_ALL;
              end
              CHAR_NEWLINE: begin
                // No glyph; WRITE is a dead cycle so timing matches printables
                cursor_x <= '0;
                cursor_y <= next_y;
                line_adv <= 1'b1;
                state    <= WRITE;
              end
              CHAR_BACKSPACE: begin
                state <= WRITE;
                if (cursor_x != '0 || cursor_y != '0) begin
                  tg_write_en <= 1'b1;
                  tg_addr     <= bs_addr;
                  tg_input    <= BLANK_GLYPH;
                  cursor_x    <= bs_x;
                  cursor_y    <= bs_y;
                end
              end
              default: begin
                tg_write_en <= 1'b1;
                tg_addr     <= cursor_addr;
                tg_input    <= char_in;
                state       <= WRITE;
                if (cursor_x == X_LAST) begin
                  cursor_x <= '0;
                  cursor_y <= next_y;
                  line_adv <= 1'b1;
                end else begin
                  cursor_x <= cursor_x + 1'b1;
                end
              end
            endcase
          end
        end

        WRITE: begin
          if (line_adv) begin
            // Cursor already sits on the destination row, so row_base targets it
            tg_write_en <= 1'b1;
            tg_addr     <= row_base;
            tg_input    <= BLANK_GLYPH;
            clear_cnt   <= CW'(1);
            state       <= CLEAR_ROW;
          end else begin
            tg_write_en <= 1'b0;
            ready       <= 1'b1;
            state       <= IDLE;
          end
        end

        CLEAR_ROW: begin
          if (clear_cnt == ROW_END) begin
            tg_write_en <= 1'b0;
            ready       <= 1'b1;
            state       <= IDLE;
          end else begin
            tg_write_en <= 1'b1;
            tg_addr     <= row_base + AW'(clear_cnt);
            clear_cnt   <= clear_cnt + 1'b1;
          end
        end

        CLEAR_ALL: begin
          if (clear_cnt == ALL_END) begin
            tg_write_en <= 1'b0;
            ready       <= 1'b1;
            state       <= IDLE;
          end else begin
            tg_write_en <= 1'b1;
            tg_addr     <= AW'(clear_cnt);
            clear_cnt   <= clear_cnt + 1'b1;
          end
        end

        default: begin
          tg_write_en <= 1'b0;
          ready       <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign char_ready_out = ready;
  assign cursor_x_out   = cursor_x;
  assign cursor_y_out   = cursor_y;

endmodule
